cp0_timer_irq: RTL and testbench

- Parametrised next-generation coprocessor-0 for the MIPS pipeline.
- Holds SR, Cause, EPC and PrId, and arbitrates exception entry and ERET redirects for the pipeline.
- Adds a configurable number of external interrupt lines, a Count/Compare timer with a programmable prescaler and a sticky timer interrupt, and a configurable handler address.
- Sits beside the memory stage; the pipeline drives exception info and consumes jump/jumpAddress/interruptNow.

---
 rtl/cp0_timer_irq.sv | 163 ++++++++++++++++
 tb/tb_cp0_timer_irq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_irq.sv
// Coprocessor-0 for the MIPS pipeline: SR/Cause/EPC/PrId, exception and ERET redirect,
// external interrupt lines and an optional prescaled Count/Compare timer interrupt.
module cp0_timer_irq #(
  parameter int          NUM_IRQ      = 6,
  parameter bit          TIMER_EN     = 1'b1,
  parameter int          CNT_DIV      = 2,
  parameter logic [31:0] HANDLER_ADDR = 32'h00004180,
  parameter logic [31:0] PRID         = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeEnable,
  input  logic [4:0]         number,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  input  logic               hasExceptionInPipeline,
  input  logic               isException,
  input  logic               isBD,
  input  logic [4:0]         exceptionCause,
  input  logic [31:0]        exceptionPC,
  output logic               jump,
  output logic [31:0]        jumpAddress,
  output logic               interruptNow,
  input  logic [NUM_IRQ-1:0] externalInterrupt,
  output logic               timerInterrupt
);

  localparam logic [4:0] causeERET = 5'b10000;
  localparam int         PW        = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

  logic [31:0] sr;
  logic [31:0] epc;
  logic        causeBd;
  logic [9:0]  causeLow;
  logic [5:0]  causeIp;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [5:0]  ipExt;
  logic [5:0]  ipLive;
  logic        ie;
  logic        exl;
  logic        isEret;
  logic        takeExc;
  logic        doWrite;

  assign ie  = sr[0];
  assign exl = sr[1];

  // Lines beyond NUM_IRQ tie to zero so the IP field is always 6 bits wide.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : gIp
      if (gi < NUM_IRQ) begin : gUsed
        assign ipExt[gi] = externalInterrupt[gi];
      end else begin : gUnused
        assign ipExt[gi] = 1'b0;
      end
    end
  endgenerate

  assign ipLive = ipExt | {ti, 5'b00000};

  assign isEret  = isException & exl & (exceptionCause == causeERET);
  assign takeExc = isException & ~exl & (exceptionCause != causeERET);
  assign doWrite = writeEnable & ~isException;

  assign jump         = isEret | takeExc;
  assign jumpAddress  = isEret ? epc : HANDLER_ADDR;
  assign interruptNow = ie & ~exl & ~hasExceptionInPipeline & (|(ipLive & sr[15:10]));
  assign timerInterrupt = ti;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= 32'h0000FC02;
      epc      <= 32'h0;
      causeBd  <= 1'b0;
      causeLow <= 10'h0;
      causeIp  <= 6'h0;
    end else begin
      causeIp <= ipLive;
      if (takeExc) begin
        sr[1]         <= 1'b1;
        causeBd       <= isBD;
        causeLow[6:2] <= exceptionCause;
        epc           <= isBD ? (exceptionPC - 32'd4) : exceptionPC;
      end else if (isEret) begin
        sr[1] <= 1'b0;
      end else if (doWrite) begin
        case (number)
          5'd12: sr <= writeData;
          5'd13: begin
            causeBd  <= writeData[31];
            causeLow <= writeData[9:0];
          end
          5'd14: epc <= writeData;
          default: ;
        endcase
      end
    end
  end

  generate
    if (TIMER_EN) begin : gTimer
      logic [PW-1:0] prescaler;
      logic          tick;
      logic          countWrite;
      logic          compareWrite;
      logic [31:0]   countNext;

      assign tick         = (prescaler == PW'(CNT_DIV - 1));
      assign countWrite   = doWrite & (number == 5'd9);
      assign compareWrite = doWrite & (number == 5'd11);
      assign countNext    = count + 32'd1;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count     <= 32'h0;
          compare   <= 32'hFFFFFFFF;
          prescaler <= '0;
          ti        <= 1'b0;
        end else begin
          if (countWrite) begin
            count     <= writeData;
            prescaler <= '0;
          end else if (tick) begin
            count     <= countNext;
            prescaler <= '0;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
          if (compareWrite) begin
            compare <= writeData;
          end
          // A Compare write wins over a match on the same edge.
          if (compareWrite) begin
            ti <= 1'b0;
          end else if (tick && !countWrite && (countNext == compare)) begin
            ti <= 1'b1;
          end
        end
      end
    end else begin : gNoTimer
      assign count   = 32'h0;
      assign compare = 32'h0;
      assign ti      = 1'b0;
    end
  endgenerate

  always_comb begin
    readData = 32'h0;
    case (number)
      5'd9:  readData = count;
      5'd11: readData = compare;
      5'd12: readData = sr;
      5'd13: readData = {causeBd, ti, 14'h0, causeIp, causeLow};
      5'd14: readData = epc;
      5'd15: readData = PRID;
      default: readData = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Directed bench for cp0_timer_irq: reset, exception/ERET, interrupt masking,
// timer match, simultaneous events and wrap-around cases.
module tb_cp0_timer_irq;

  localparam logic [4:0] causeERET = 5'b10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        writeEnable;
  logic [4:0]  number;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        hasExceptionInPipeline;
  logic        isException;
  logic        isBD;
  logic [4:0]  exceptionCause;
  logic [31:0] exceptionPC;
  logic        jump;
  logic [31:0] jumpAddress;
  logic        interruptNow;
  logic [5:0]  externalInterrupt;
  logic        timerInterrupt;

  int vectors = 0;
  int errs    = 0;

  cp0_timer_irq #(
    .NUM_IRQ(6), .TIMER_EN(1'b1), .CNT_DIV(2),
    .HANDLER_ADDR(32'h00004180), .PRID(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .number(number),
    .writeData(writeData), .readData(readData),
    .hasExceptionInPipeline(hasExceptionInPipeline), .isException(isException),
    .isBD(isBD), .exceptionCause(exceptionCause), .exceptionPC(exceptionPC),
    .jump(jump), .jumpAddress(jumpAddress), .interruptNow(interruptNow),
    .externalInterrupt(externalInterrupt), .timerInterrupt(timerInterrupt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] num, input logic [31:0] exp, input string tag);
    number = num;
    #1;
    chk(tag, readData, exp);
  endtask

  task automatic mtc0(input logic [4:0] num, input logic [31:0] data);
    writeEnable = 1'b1;
    number      = num;
    writeData   = data;
    tick();
    writeEnable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; writeEnable = 1'b0; number = 5'd0; writeData = 32'h0;
    hasExceptionInPipeline = 1'b0; isException = 1'b0; isBD = 1'b0;
    exceptionCause = 5'd0; exceptionPC = 32'h0; externalInterrupt = 6'b0;
    tick(); tick();
    reset = 1'b0;

    // Asynchronous reset between edges
    mtc0(5'd12, 32'h0);
    rd(5'd12, 32'h0, "sr_written_zero");
    #1 reset = 1'b1;
    rd(5'd12, 32'h0000FC02, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd15, 32'hDEADBEEF, "rst_prid");
    rd(5'd11, 32'hFFFFFFFF, "rst_compare");
    chk("rst_jump", {31'b0, jump}, 32'd0);
    chk("rst_intr", {31'b0, interruptNow}, 32'd0);
    tick();
    reset = 1'b0;

    // Exception entry from a delay slot, then ERET
    mtc0(5'd12, 32'h0000FC01);
    isException = 1'b1; exceptionCause = 5'd4; isBD = 1'b1; exceptionPC = 32'h00003010;
    #1;
    chk("exc_jump", {31'b0, jump}, 32'd1);
    chk("exc_addr", jumpAddress, 32'h00004180);
    tick();
    isException = 1'b0; isBD = 1'b0;
    rd(5'd14, 32'h0000300C, "exc_epc");
    number = 5'd13; #1;
    chk("exc_cause", readData & 32'h8000007C, 32'h80000010);
    rd(5'd12, 32'h0000FC03, "exc_sr");
    isException = 1'b1; exceptionCause = causeERET;
    #1;
    chk("eret_jump", {31'b0, jump}, 32'd1);
    chk("eret_addr", jumpAddress, 32'h0000300C);
    tick();
    isException = 1'b0; exceptionCause = 5'd0;
    rd(5'd12, 32'h0000FC01, "eret_sr");

    // External interrupt masking
    mtc0(5'd12, 32'h00000401);
    externalInterrupt = 6'b000010; #1;
    chk("irq_masked", {31'b0, interruptNow}, 32'd0);
    externalInterrupt = 6'b000001; #1;
    chk("irq_taken", {31'b0, interruptNow}, 32'd1);
    hasExceptionInPipeline = 1'b1; #1;
    chk("irq_pipe_block", {31'b0, interruptNow}, 32'd0);
    hasExceptionInPipeline = 1'b0;
    tick();
    number = 5'd13; #1;
    chk("cause_ip", readData & 32'h0000FC00, 32'h00000400);
    externalInterrupt = 6'b0;

    // Timer match with CNT_DIV=2
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd5);
    for (int i = 0; i < 5; i++) tick();
    chk("ti_before", {31'b0, timerInterrupt}, 32'd0);
    rd(5'd9, 32'd7, "count_7");
    tick();
    chk("ti_set", {31'b0, timerInterrupt}, 32'd1);
    rd(5'd9, 32'd8, "count_8");
    tick();
    number = 5'd13; #1;
    chk("cause_ti_ip", readData & 32'hC0008000, 32'hC0008000);
    mtc0(5'd12, 32'h00008001);
    chk("ti_intr", {31'b0, interruptNow}, 32'd1);
    mtc0(5'd11, 32'd8);
    chk("ti_cleared", {31'b0, timerInterrupt}, 32'd0);
    chk("ti_intr_gone", {31'b0, interruptNow}, 32'd0);

    // Exception drops a same-cycle SR write
    isException = 1'b1; exceptionCause = 5'd4; isBD = 1'b0; exceptionPC = 32'h00000100;
    writeEnable = 1'b1; number = 5'd12; writeData = 32'h0;
    tick();
    isException = 1'b0; writeEnable = 1'b0;
    rd(5'd12, 32'h00008003, "simul_sr");
    rd(5'd14, 32'h00000100, "simul_epc");
    isException = 1'b1; exceptionCause = causeERET;
    tick();
    isException = 1'b0; exceptionCause = 5'd0;

    // Count write on a tick edge overrides the increment
    mtc0(5'd9, 32'd100);
    tick();
    mtc0(5'd9, 32'd200);
    rd(5'd9, 32'd200, "count_write_on_tick");

    // Count wrap into Compare=0
    mtc0(5'd11, 32'h0);
    mtc0(5'd9, 32'hFFFFFFFF);
    tick();
    rd(5'd9, 32'hFFFFFFFF, "wrap_pre");
    chk("wrap_ti_pre", {31'b0, timerInterrupt}, 32'd0);
    tick();
    rd(5'd9, 32'h0, "wrap_count");
    chk("wrap_ti", {31'b0, timerInterrupt}, 32'd1);

    // BD exception at PC 0
    isException = 1'b1; exceptionCause = 5'd4; isBD = 1'b1; exceptionPC = 32'h0;
    tick();
    isException = 1'b0; isBD = 1'b0;
    rd(5'd14, 32'hFFFFFFFC, "epc_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
